// File: rtl/knn_seq_ctrl.sv
// knn_seq_ctrl
//   Sequencer for the KNN classification datapath. After a start request it
//   latches and validates the ROI, then walks every pixel in row-major order.
//   For each pixel it steps through all dictionary colours, tracks the
//   nearest colour from the returned distances, and votes for it. After the
//   scan it picks the colour with the most votes and reports it.
//
// Ports
//   clk_en        clock, all logic on the rising edge
//   reset         synchronous reset, active-high
//   start         begin classification (accepted only while idle)
//   postion_lu_x  ROI top-left column
//   postion_lu_y  ROI top-left row
//   postion_rd_x  ROI bottom-right column (inclusive)
//   postion_rd_y  ROI bottom-right row (inclusive)
//   pix_row       pixel row address to the pixel buffer
//   pix_col       pixel column address to the pixel buffer
//   dic_idx       dictionary index
//   addr_vld      pix_row/pix_col/dic_idx valid this cycle
//   distance      distance for the tuple issued in the previous cycle
//   busy          high whenever the sequencer is not idle
//   knn_result    winning colour index, held until the next result
//   knn_outflag   one-cycle pulse, knn_result valid
//   roi_err       one-cycle pulse, ROI rejected (inverted corners)

module knn_seq_ctrl #(
  parameter int COLOR_NUM = 5,
  parameter int DIST_W    = 14,
  parameter int VOTE_W    = 21
) (
  input  logic              clk_en,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        postion_lu_x,
  input  logic [9:0]        postion_lu_y,
  input  logic [9:0]        postion_rd_x,
  input  logic [9:0]        postion_rd_y,
  output logic [9:0]        pix_row,
  output logic [9:0]        pix_col,
  output logic [2:0]        dic_idx,
  output logic              addr_vld,
  input  logic [DIST_W-1:0] distance,
  output logic              busy,
  output logic [3:0]        knn_result,
  output logic              knn_outflag,
  output logic              roi_err
);

  localparam logic [2:0] LAST_M = 3'(COLOR_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_DRAIN,
    S_VOTE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [9:0] lu_x_r, lu_y_r, rd_x_r, rd_y_r;
  logic       roi_bad;
  logic       scan_last;

  // issue stage
  logic [9:0] row_p0, col_p0;
  logic [2:0] m_p0;

  // tag stage: pairs with the incoming distance
  logic [2:0] tag_m_p1;
  logic       tag_v_p1;

  // running minimum for the pixel being evaluated
  logic [DIST_W-1:0] min_p2;
  logic [2:0]        arg_p2;
  logic [DIST_W-1:0] cand_min;
  logic [2:0]        cand_arg;
  logic              pix_done;

  logic [VOTE_W-1:0] votes [COLOR_NUM];
  logic [2:0]        vote_idx;
  logic [2:0]        best_idx;
  logic [VOTE_W-1:0] best_cnt;
  logic [VOTE_W-1:0] cur_cnt;
  logic              take_new;
  logic [2:0]        fin_idx;

  function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign roi_bad   = (rd_x_r < lu_x_r) || (rd_y_r < lu_y_r);
  assign scan_last = (m_p0 == LAST_M) && (col_p0 == rd_x_r) && (row_p0 == rd_y_r);

  assign pix_row     = row_p0;
  assign pix_col     = col_p0;
  assign dic_idx     = m_p0;
  assign addr_vld    = (state == S_SCAN);
  assign busy        = (state != S_IDLE);
  assign knn_outflag = (state == S_DONE);

  always_ff @(posedge clk_en) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    roi_err   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: begin
        if (roi_bad) begin
          roi_err   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SCAN;
        end
      end
      S_SCAN:  if (scan_last) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_VOTE;
      S_VOTE:  if (vote_idx == LAST_M) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: ROI latch and address walk ----
  always_ff @(posedge clk_en) begin
    if (reset) begin
      lu_x_r <= '0;
      lu_y_r <= '0;
      rd_x_r <= '0;
      rd_y_r <= '0;
      row_p0 <= '0;
      col_p0 <= '0;
      m_p0   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        lu_x_r <= postion_lu_x;
        lu_y_r <= postion_lu_y;
        rd_x_r <= postion_rd_x;
        rd_y_r <= postion_rd_y;
      end
      if (state == S_CHECK) begin
        row_p0 <= lu_y_r;
        col_p0 <= lu_x_r;
        m_p0   <= '0;
      end else if (state == S_SCAN) begin
        if (m_p0 == LAST_M) begin
          m_p0 <= '0;
          if (col_p0 == rd_x_r) begin
            col_p0 <= lu_x_r;
            // after the final tuple the row stays put; the FSM leaves SCAN
            if (row_p0 != rd_y_r) row_p0 <= row_p0 + 10'd1;
          end else begin
            col_p0 <= col_p0 + 10'd1;
          end
        end else begin
          m_p0 <= m_p0 + 3'd1;
        end
      end
    end
  end

  // ---- stage p1: tag the issued index so it meets its distance ----
  always_ff @(posedge clk_en) begin
    if (reset) begin
      tag_v_p1 <= 1'b0;
      tag_m_p1 <= '0;
    end else begin
      tag_v_p1 <= addr_vld;
      tag_m_p1 <= m_p0;
    end
  end

  // index 0 always seeds the minimum; strict compare keeps the lower index on ties
  always_comb begin
    cand_min = min_p2;
    cand_arg = arg_p2;
    if (tag_m_p1 == 3'd0) begin
      cand_min = distance;
      cand_arg = 3'd0;
    end else if (distance < min_p2) begin
      cand_min = distance;
      cand_arg = tag_m_p1;
    end
  end

  assign pix_done = tag_v_p1 && (tag_m_p1 == LAST_M);

  // ---- stage p2: running minimum and vote accumulation ----
  always_ff @(posedge clk_en) begin
    if (reset) begin
      min_p2 <= '0;
      arg_p2 <= '0;
    end else if (tag_v_p1) begin
      min_p2 <= cand_min;
      arg_p2 <= cand_arg;
    end
  end

  always_ff @(posedge clk_en) begin
    if (reset || state == S_CHECK) begin
      for (int i = 0; i < COLOR_NUM; i++) votes[i] <= '0;
    end else if (pix_done) begin
      for (int i = 0; i < COLOR_NUM; i++)
        if (cand_arg == 3'(i)) votes[i] <= sat_inc(votes[i]);
    end
  end

  // ---- vote scan: strict greater keeps the lowest index on ties ----
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < COLOR_NUM; i++)
      if (vote_idx == 3'(i)) cur_cnt = votes[i];
  end

  assign take_new = (vote_idx == 3'd0) || (cur_cnt > best_cnt);
  assign fin_idx  = take_new ? vote_idx : best_idx;

  always_ff @(posedge clk_en) begin
    if (reset) begin
      vote_idx   <= '0;
      best_idx   <= '0;
      best_cnt   <= '0;
      knn_result <= '0;
    end else if (state == S_DRAIN) begin
      vote_idx <= '0;
    end else if (state == S_VOTE) begin
      vote_idx <= vote_idx + 3'd1;
      best_idx <= fin_idx;
      if (take_new) best_cnt <= cur_cnt;
      if (vote_idx == LAST_M) knn_result <= {1'b0, fin_idx};
    end
  end

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb_knn_seq_ctrl
//   Scoreboard bench for knn_seq_ctrl. Each run pushes its expected address
//   sequence and expected result/latency into queues; a negedge monitor pops
//   and compares whenever the DUT issues an address or raises knn_outflag.

module tb_knn_seq_ctrl;

  localparam int C  = 5;
  localparam int DW = 14;

  logic          clk_en = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    lu_x, lu_y, rd_x, rd_y;
  logic [9:0]    pix_row, pix_col;
  logic [2:0]    dic_idx;
  logic          addr_vld;
  logic [DW-1:0] distance;
  logic          busy;
  logic [3:0]    knn_result;
  logic          knn_outflag;
  logic          roi_err;

  always #5 clk_en = ~clk_en;

  knn_seq_ctrl #(.COLOR_NUM(C), .DIST_W(DW), .VOTE_W(21)) dut (
    .clk_en      (clk_en),
    .reset       (reset),
    .start       (start),
    .postion_lu_x(lu_x),
    .postion_lu_y(lu_y),
    .postion_rd_x(rd_x),
    .postion_rd_y(rd_y),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .dic_idx     (dic_idx),
    .addr_vld    (addr_vld),
    .distance    (distance),
    .busy        (busy),
    .knn_result  (knn_result),
    .knn_outflag (knn_outflag),
    .roi_err     (roi_err)
  );

  typedef struct {
    int res;
    int lat;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [22:0] addr_q[$];
  exp_t        res_q[$];
  logic [DW-1:0] tab [64][8];
  int          g_lux, g_luy, g_w, g_h;
  int          cyc = 0;
  int          last_start = 0;
  bit          err_ok = 0;
  logic [DW-1:0] pend = '1;
  int          pidx;
  exp_t        e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_en) cyc <= cyc + 1;

  // distance model: answer for the tuple seen in the previous cycle
  always @(negedge clk_en) begin
    pend = '1;
    if (addr_vld) begin
      pidx = (int'(pix_row) - g_luy) * g_w + (int'(pix_col) - g_lux);
      if (pidx >= 0 && pidx < 64) pend = tab[pidx][dic_idx];
    end
  end

  always @(posedge clk_en) begin
    #1;
    distance = pend;
  end

  // monitor
  always @(negedge clk_en) begin
    if (start && !busy && !reset) last_start = cyc;
    if (addr_vld) begin
      if (addr_q.size() == 0) check_eq("addr_extra", 1, 0);
      else check_eq("addr", {9'd0, pix_row, pix_col, dic_idx}, {9'd0, addr_q.pop_front()});
    end
    if (knn_outflag) begin
      if (res_q.size() == 0) check_eq("outflag_unexp", 1, 0);
      else begin
        e = res_q.pop_front();
        check_eq("knn_result", knn_result, e.res);
        check_eq("latency", cyc - last_start, e.lat);
      end
    end
    if (roi_err && !err_ok) check_eq("roi_err_unexp", 1, 0);
  end

  task automatic set_roi(input int lx, input int ly, input int rx, input int ry);
    lu_x = 10'(lx); lu_y = 10'(ly); rd_x = 10'(rx); rd_y = 10'(ry);
    g_lux = lx; g_luy = ly; g_w = rx - lx + 1; g_h = ry - ly + 1;
  endtask

  task automatic fill_argmin(input int p, input int am);
    for (int m = 0; m < 8; m++) tab[p][m] = (m == am) ? DW'(3) : DW'(10 + m);
  endtask

  task automatic fill_random(input int np);
    for (int p = 0; p < np; p++)
      for (int m = 0; m < 8; m++)
        tab[p][m] = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom_range(0, 7));
  endtask

  // expected address order plus an independent nearest/vote model
  task automatic push_run();
    int votes[8];
    int am, best;
    logic [DW-1:0] mn;
    for (int i = 0; i < 8; i++) votes[i] = 0;
    for (int r = 0; r < g_h; r++)
      for (int c = 0; c < g_w; c++) begin
        for (int m = 0; m < C; m++)
          addr_q.push_back({10'(g_luy + r), 10'(g_lux + c), 3'(m)});
        am = 0;
        mn = tab[r * g_w + c][0];
        for (int m = 1; m < C; m++)
          if (tab[r * g_w + c][m] < mn) begin
            mn = tab[r * g_w + c][m];
            am = m;
          end
        votes[am]++;
      end
    best = 0;
    for (int i = 1; i < C; i++) if (votes[i] > votes[best]) best = i;
    res_q.push_back('{best, g_w * g_h * C + C + 3});
  endtask

  task automatic pulse_start();
    @(posedge clk_en); #1;
    start = 1'b1;
    @(posedge clk_en); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk_en); #2;
      if (res_q.size() == 0 && addr_q.size() == 0 && !busy) break;
    end
    if (i == budget) begin
      check_eq("timeout", 0, 1);
      res_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    int lx, ly, w, h, i;
    reset = 1'b1; start = 1'b0; distance = '0;
    set_roi(0, 0, 0, 0);
    for (int p = 0; p < 64; p++) fill_argmin(p, 0);
    repeat (3) @(posedge clk_en);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk_en);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_vld", addr_vld, 0);
    check_eq("rst_result", knn_result, 0);
    check_eq("rst_outflag", knn_outflag, 0);
    check_eq("rst_roi_err", roi_err, 0);
    check_eq("rst_addr", {pix_row, pix_col, dic_idx}, 0);

    // T1: 1x1 ROI, tie between m=1 and m=3 keeps 1
    set_roi(3, 3, 3, 3);
    tab[0][0] = 9; tab[0][1] = 4; tab[0][2] = 7; tab[0][3] = 4; tab[0][4] = 12;
    push_run();
    pulse_start();
    wait_done(200);
    repeat (3) @(posedge clk_en);
    #1 check_eq("t1_hold", knn_result, 1);

    // T2: 2x2 ROI, argmins 2,2,0,3
    set_roi(0, 0, 1, 1);
    fill_argmin(0, 2); fill_argmin(1, 2); fill_argmin(2, 0); fill_argmin(3, 3);
    push_run();
    pulse_start();
    wait_done(200);
    #1 check_eq("t2_hold", knn_result, 2);

    // T3: 2x1 ROI, argmins 4,1 -> equal votes, lowest index wins
    set_roi(7, 2, 8, 2);
    fill_argmin(0, 4); fill_argmin(1, 1);
    push_run();
    pulse_start();
    wait_done(200);
    #1 check_eq("t3_hold", knn_result, 1);

    // T4: inverted columns -> roi_err, no scan
    set_roi(5, 0, 4, 0);
    err_ok = 1;
    pulse_start();
    @(negedge clk_en);
    check_eq("t4_roi_err", roi_err, 1);
    check_eq("t4_busy_check", busy, 1);
    @(negedge clk_en);
    check_eq("t4_roi_err_end", roi_err, 0);
    check_eq("t4_busy_low", busy, 0);
    check_eq("t4_vld", addr_vld, 0);
    err_ok = 0;
    repeat (4) @(posedge clk_en);
    #1 check_eq("t4_result_kept", knn_result, 1);

    // random ROIs near the top of the coordinate range, ties likely
    for (int k = 0; k < 3; k++) begin
      w = $urandom_range(1, 4); h = $urandom_range(1, 3);
      lx = 1024 - w - $urandom_range(0, 2); ly = 1024 - h - $urandom_range(0, 2);
      set_roi(lx, ly, lx + w - 1, ly + h - 1);
      fill_random(w * h);
      push_run();
      pulse_start();
      wait_done(300);
    end

    // T5: reset at the 7th SCAN cycle (cycle 8)
    set_roi(0, 0, 1, 1);
    fill_argmin(0, 1); fill_argmin(1, 1); fill_argmin(2, 1); fill_argmin(3, 4);
    push_run();
    pulse_start();
    repeat (7) @(posedge clk_en);
    #1 reset = 1'b1;
    @(posedge clk_en);
    #1 reset = 1'b0;
    addr_q.delete();
    res_q.delete();
    @(negedge clk_en);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_vld", addr_vld, 0);
    check_eq("t5_dic_idx", dic_idx, 0);
    check_eq("t5_result", knn_result, 0);
    repeat (6) @(posedge clk_en);
    set_roi(2, 4, 3, 4);
    fill_argmin(0, 3); fill_argmin(1, 3);
    push_run();
    pulse_start();
    wait_done(200);

    // T6: extra start pulse mid-SCAN ignored; held start re-triggers from IDLE
    set_roi(1, 1, 2, 1);
    fill_random(2);
    push_run();
    push_run();
    pulse_start();
    repeat (3) @(posedge clk_en);
    #1 start = 1'b1;
    @(posedge clk_en);
    #1 start = 1'b0;
    repeat (4) @(posedge clk_en);
    #1 start = 1'b1;
    for (i = 0; i < 100; i++) begin
      @(posedge clk_en); #2;
      if (res_q.size() < 2) break;
    end
    check_eq("t6_first_done", (i < 100), 1);
    check_eq("t6_idle_gap", busy, 0);
    @(posedge clk_en); #1;
    start = 1'b0;
    check_eq("t6_retrigger", busy, 1);
    wait_done(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

endmodule
